regdst_pipe: RTL
================

REGDST_PIPE -- requirements
Module: regdst_pipe

Interface
REQ-001 Parameter REG_W, default 5, width of register specifiers.
REQ-002 Parameter DEPTH, default 2, number of registered stages after E (stage 1 = M, stage 2 = W); legal range 1..4.
REQ-003 Parameter LINK_REG, default 31, register number selected in link mode.
REQ-004 Localparam FW_W = clog2(DEPTH+1), width of forward-select outputs.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 RtE  input  REG_W  rt field, E stage.
REQ-008 RdE  input  REG_W  rd field, E stage.
REQ-009 RegDstE  input  2  destination mode: 00 rt, 01 rd, 10 LINK_REG, 11 rt.
REQ-010 RegWriteE  input  1  E-stage instruction writes the register file.
REQ-011 RsE  input  REG_W  source A specifier for forwarding lookup.
REQ-012 stall  input  1  hold all pipe stages.
REQ-013 flush  input  1  inject a bubble into stage 1.
REQ-014 WriteRegE  output  REG_W  combinational destination, E stage.
REQ-015 WriteRegPipe  output  DEPTH*REG_W  stage k destination at bits [k*REG_W-1:(k-1)*REG_W].
REQ-016 RegWritePipe  output  DEPTH  stage k write-enable at bit k-1.
REQ-017 ForwardAE, ForwardBE  output  FW_W each  forwarding source for RsE and RtE: 0 none, k = stage k.

Function
REQ-018 WriteRegE SHALL follow the RegDstE mode table combinationally, with zero cycle latency.
REQ-019 On a clock edge with reset=0, stall=0, flush=0: stage 1 SHALL load {WriteRegE, RegWriteE}, and stage k SHALL load stage k-1 for k=2..DEPTH.
REQ-020 With stall=1 and flush=0, all stages SHALL hold their values.
REQ-021 With flush=1, stage 1 SHALL load {0, 0}; when stall=0, stages 2..DEPTH SHALL advance, and when stall=1 they SHALL hold.
REQ-022 Priority SHALL be reset > flush > stall > advance.
REQ-023 ForwardAE SHALL equal the lowest k for which RegWritePipe[k-1]=1, stage k destination == RsE, and RsE != 0; otherwise it SHALL be 0.
REQ-024 ForwardBE SHALL follow the same rule as ForwardAE, using RtE.
REQ-025 Forward outputs SHALL be combinational from current stage contents and the E-stage sources, with no cycle of latency.
REQ-026 Register 0 SHALL never be reported as a forward match, regardless of write-enable.
REQ-027 Mode 11 SHALL behave identically to mode 00; no error indication is produced.
REQ-028 Stage contents SHALL be independent of RsE.
REQ-029 Stage contents SHALL be independent of RtE, except through the WriteRegE mode table.

Reset
REQ-030 While reset=1 at a clock edge, every stage destination and write-enable SHALL become 0.
REQ-031 After reset, ForwardAE and ForwardBE SHALL read 0.
REQ-032 A reset arriving mid-stream SHALL discard all in-flight entries in the same edge, overriding stall and flush.
REQ-033 WriteRegE SHALL remain combinational, unaffected by reset.

Configuration
REQ-034 Macro REGDST_ZERO_SUPPRESS_EN, when defined: the enable loaded into stage 1 SHALL be RegWriteE AND (WriteRegE != 0), so writes to register 0 never occupy a valid slot.
REQ-035 Without REGDST_ZERO_SUPPRESS_EN: stage 1 SHALL load RegWriteE unchanged; REQ-026 still suppresses register-0 forwarding.

Verification
REQ-036 Reset pulse, then RegDstE=01, RdE=7, RegWriteE=1 for one cycle -> WriteRegE=7 immediately; stage 1 = {7,1} after 1 edge; stage 2 = {7,1} after 2 edges.
REQ-037 RegDstE=10 -> WriteRegE=31; next cycle RsE=31 -> ForwardAE=1; one cycle later -> ForwardAE=2.
REQ-038 Stage 1 = {9,1}, stage 2 = {9,1}, RtE=9 -> ForwardBE=1 (youngest wins); clear stage 1 via flush -> ForwardBE=2.
REQ-039 stall=1 for 3 cycles with changing E inputs -> stages unchanged; stall=1 with flush=1 -> stage 1 = {0,0}, stage 2 held.
REQ-040 RegDstE=00, RtE=0, RegWriteE=1 -> RsE=0 yields ForwardAE=0 always; stage 1 enable = 0 with macro defined, 1 without.
REQ-041 Mid-stream reset with stall=1 and flush=1 -> all stages {0,0} next edge; repeat REQ-036 with DEPTH=4, REG_W=6 -> entry reaches stage 4 after 4 edges.

Source files
------------

// File: rtl/regdst_pipe.sv
// Destination-register select with a DEPTH-stage {dest, write-enable} pipe and forwarding lookup.
// Optional macro REGDST_ZERO_SUPPRESS_EN: writes to register 0 never occupy a valid slot.
module regdst_pipe #(
   parameter int REG_W    = 5,
   parameter int DEPTH    = 2,
   parameter int LINK_REG = 31,
   localparam int FW_W    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [REG_W-1:0]       RtE,
   input  logic [REG_W-1:0]       RdE,
   input  logic [1:0]             RegDstE,
   input  logic                   RegWriteE,
   input  logic [REG_W-1:0]       RsE,
   input  logic                   stall,
   input  logic                   flush,
   output logic [REG_W-1:0]       WriteRegE,
   output logic [DEPTH*REG_W-1:0] WriteRegPipe,
   output logic [DEPTH-1:0]       RegWritePipe,
   output logic [FW_W-1:0]        ForwardAE,
   output logic [FW_W-1:0]        ForwardBE
);

   // Packed so that element k-1 lands at bits [k*REG_W-1:(k-1)*REG_W].
   logic [DEPTH-1:0][REG_W-1:0] dest_q, dest_d;
   logic [DEPTH-1:0]            we_q, we_d;
   logic                        we_in;

   always_comb begin
      case (RegDstE)
         2'b01:   WriteRegE = RdE;
         2'b10:   WriteRegE = REG_W'(LINK_REG);
         default: WriteRegE = RtE;
      endcase
   end

`ifdef REGDST_ZERO_SUPPRESS_EN
   assign we_in = RegWriteE && (WriteRegE != '0);
`else
   assign we_in = RegWriteE;
`endif

   always_comb begin
      dest_d = dest_q;
      we_d   = we_q;
      if (flush) begin
         dest_d[0] = '0;
         we_d[0]   = 1'b0;
      end else if (!stall) begin
         dest_d[0] = WriteRegE;
         we_d[0]   = we_in;
      end
      if (!stall) begin
         for (int unsigned k = 1; k < DEPTH; k++) begin
            dest_d[k] = dest_q[k-1];
            we_d[k]   = we_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dest_q <= '0;
         we_q   <= '0;
      end else begin
         dest_q <= dest_d;
         we_q   <= we_d;
      end
   end

   // Youngest matching stage wins, so only the first hit is kept.
   always_comb begin
      logic hit_a, hit_b;
      ForwardAE = '0;
      ForwardBE = '0;
      hit_a     = 1'b0;
      hit_b     = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (!hit_a && we_q[k] && (RsE != '0) && (dest_q[k] == RsE)) begin
            ForwardAE = FW_W'(k + 1);
            hit_a     = 1'b1;
         end
         if (!hit_b && we_q[k] && (RtE != '0) && (dest_q[k] == RtE)) begin
            ForwardBE = FW_W'(k + 1);
            hit_b     = 1'b1;
         end
      end
   end

   assign WriteRegPipe = dest_q;
   assign RegWritePipe = we_q;

endmodule
